display_driver: RTL and testbench

Downstream consumer of the calculator core's `status`/`pos`/`dig` stream. Holds an 8-digit frame buffer written one digit per cycle by the core and time-multiplexes it onto an 8-digit common-anode 7-segment display. It also clears the frame when a new operand starts, shows "Erro" while the core is in error, and optionally blanks leading zeros.

---
 rtl/calc_pkg.sv | 25 ++
 rtl/seg7_decoder.sv | 31 +++
 rtl/display_driver.sv | 124 ++++++++++++
 tb/tb_display_driver.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// calc_pkg: types and constants shared by the calculator core and the display driver.
// Contents: status enum, frame-buffer blank code, internal render codes, segment patterns.
// Segment patterns are active-low, bit order {g,f,e,d,c,b,a}.
package calc_pkg;

   typedef enum logic [1:0] {
      ERRO    = 2'd0,
      PRONTA  = 2'd1,
      OCUPADA = 2'd2,
      IMPRIME = 2'd3
   } status_t;

   localparam logic [3:0] BLANK_CODE = 4'hF;

   // Codes 0..9 are digits; these extra codes are only produced by the ERRO renderer.
   localparam logic [3:0] CODE_E = 4'hA;
   localparam logic [3:0] CODE_R = 4'hB;
   localparam logic [3:0] CODE_O = 4'hC;

   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [6:0] SEG_E     = 7'h06;
   localparam logic [6:0] SEG_R     = 7'h2F;
   localparam logic [6:0] SEG_O     = 7'h23;

endpackage

// File: rtl/seg7_decoder.sv
// seg7_decoder: maps a 4-bit render code to an active-low 7-segment pattern.
// Ports: code_i (0..9 digits, A=E, B=r, C=o, other=blank), seg_o {g,f,e,d,c,b,a}.
// Purely combinational, zero latency, no flow control.
module seg7_decoder
   import calc_pkg::*;
(
   input  logic [3:0] code_i,
   output logic [6:0] seg_o
);

   always_comb begin
      seg_o = SEG_BLANK;
      case (code_i)
         4'd0:    seg_o = 7'h40;
         4'd1:    seg_o = 7'h79;
         4'd2:    seg_o = 7'h24;
         4'd3:    seg_o = 7'h30;
         4'd4:    seg_o = 7'h19;
         4'd5:    seg_o = 7'h12;
         4'd6:    seg_o = 7'h02;
         4'd7:    seg_o = 7'h78;
         4'd8:    seg_o = 7'h00;
         4'd9:    seg_o = 7'h10;
         CODE_E:  seg_o = SEG_E;
         CODE_R:  seg_o = SEG_R;
         CODE_O:  seg_o = SEG_O;
         default: seg_o = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/display_driver.sv
// display_driver: 8-digit frame buffer fed by the core's status/pos/dig stream, scanned
// onto a common-anode 7-segment display (an/seg/dp active-low, an[0] rightmost digit).
// Ports: clock, reset (async high), status[1:0], pos[3:0], dig[3:0] in; an[7:0], seg[6:0], dp out.
// Write lands 1 cycle after sampling; an/seg registered (1 more cycle); no backpressure.
// Optional macro DISPLAY_LZB_EN enables leading-zero blanking.
module display_driver
   import calc_pkg::*;
#(
   parameter int SCAN_DIV = 50000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [1:0] status,
   input  logic [3:0] pos,
   input  logic [3:0] dig,
   output logic [7:0] an,
   output logic [6:0] seg,
   output logic       dp
);

   localparam int            PW      = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [PW-1:0] PRE_MAX = PW'(SCAN_DIV - 1);

   status_t       st;
   status_t       prev_status_q;
   logic [3:0]    fb_q [8];
   logic [3:0]    fb_d [8];
   logic          clr;
   logic          wr;
   logic [PW-1:0] pre_q, pre_d;
   logic          pre_tc;
   logic [2:0]    scan_q, scan_d;
   logic [2:0]    p;
   logic [7:0]    lz;
   logic [3:0]    code;
   logic [6:0]    seg_dec;
   logic [7:0]    an_q;
   logic [6:0]    seg_q;

   assign st = status_t'(status);

   // Frame buffer next state: a clear blanks everything, then a legal write overrides its slot.
   always_comb begin
      clr = (prev_status_q == PRONTA) && (st == OCUPADA);
      wr  = (st == OCUPADA) && !pos[3] && (dig < 4'd10);
      for (int i = 0; i < 8; i++) begin
         fb_d[i] = clr ? BLANK_CODE : fb_q[i];
         if (wr && (pos[2:0] == 3'(i))) begin
            fb_d[i] = dig;
         end
      end
   end

   // Scan prescaler and digit index.
   always_comb begin
      pre_tc = (pre_q == PRE_MAX);
      pre_d  = pre_tc ? '0 : pre_q + PW'(1);
      scan_d = pre_tc ? scan_q + 3'd1 : scan_q;
   end

   // Buffer position shown by the current scan slot; pos 7 sits on an[0].
   assign p = 3'd7 - scan_q;

`ifdef DISPLAY_LZB_EN
   // A zero is leading if every lower position is blank or zero; pos 7 always shows.
   logic lead;
   always_comb begin
      lead = 1'b1;
      lz   = '0;
      for (int i = 0; i < 7; i++) begin
         lz[i] = lead && (fb_q[i] == 4'd0);
         lead  = lead && ((fb_q[i] == 4'd0) || (fb_q[i] == BLANK_CODE));
      end
   end
`else
   assign lz = '0;
`endif

   // Render code: "Erro" overlays the buffer without disturbing it.
   always_comb begin
      code = fb_q[p];
      if (st == ERRO) begin
         case (p)
            3'd4:       code = CODE_E;
            3'd5, 3'd6: code = CODE_R;
            3'd7:       code = CODE_O;
            default:    code = BLANK_CODE;
         endcase
      end else if (lz[p]) begin
         code = BLANK_CODE;
      end
   end

   seg7_decoder u_dec (
      .code_i (code),
      .seg_o  (seg_dec)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 8; i++) begin
            fb_q[i] <= BLANK_CODE;
         end
         prev_status_q <= PRONTA;
         pre_q         <= '0;
         scan_q        <= '0;
         an_q          <= 8'hFF;
         seg_q         <= SEG_BLANK;
      end else begin
         fb_q          <= fb_d;
         prev_status_q <= st;
         pre_q         <= pre_d;
         scan_q        <= scan_d;
         // an and seg update together so no digit ever shows its neighbour's pattern.
         an_q          <= ~(8'h01 << scan_q);
         seg_q         <= seg_dec;
      end
   end

   assign an  = an_q;
   assign seg = seg_q;
   assign dp  = 1'b1;

endmodule

// File: tb/tb_display_driver.sv
// tb_display_driver: directed stimulus with a scoreboard queue of expected scan slots;
// a monitor pops one entry at each new slot and compares an/seg (and slot length in test 1).
// SCAN_DIV = 4, clock period 10.
module tb_display_driver;

   localparam int SD = 4;
   localparam logic [1:0] S_ERRO    = 2'd0;
   localparam logic [1:0] S_PRONTA  = 2'd1;
   localparam logic [1:0] S_OCUPADA = 2'd2;
   localparam logic [1:0] S_IMPRIME = 2'd3;

   logic       clock  = 1'b0;
   logic       reset  = 1'b0;
   logic [1:0] status = S_PRONTA;
   logic [3:0] pos    = 4'hF;
   logic [3:0] dig    = 4'h0;
   wire  [7:0] an;
   wire  [6:0] seg;
   wire        dp;

   display_driver #(.SCAN_DIV(SD)) dut (
      .clock  (clock),
      .reset  (reset),
      .status (status),
      .pos    (pos),
      .dig    (dig),
      .an     (an),
      .seg    (seg),
      .dp     (dp)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic [7:0] an;
      logic [6:0] seg;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_err    = 0;
   bit   chk_len  = 1'b0;

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
      n_checks++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %h, required %h", name, act, req);
      end
   endtask

   // Monitor: every new an value is a new slot presented by the DUT.
   logic [7:0] prev_an = 8'hFF;
   int         len     = 0;
   bit         last_chk = 1'b0;
   exp_t       e;
   initial begin
      forever begin
         @(negedge clock);
         if (an !== prev_an) begin
            if (last_chk && chk_len) check("slot_len", 8'(len), 8'(SD));
            len = 1;
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               check("slot_an", an, e.an);
               check("slot_seg", {1'b0, seg}, {1'b0, e.seg});
               last_chk = 1'b1;
            end else begin
               last_chk = 1'b0;
            end
            prev_an = an;
         end else begin
            len++;
         end
      end
   end

   // segs holds the pattern for slot i (an bit i low) at segs[i*7 +: 7].
   task automatic push_frame(input logic [55:0] segs, input int nframes);
      int   t;
      exp_t x;
      logic [7:0] one;
      one = 8'h01;
      t = 0;
      while (an == 8'h7F && t < 200) begin @(posedge clock); #2; t++; end
      while (an != 8'h7F && t < 200) begin @(posedge clock); #2; t++; end
      if (t >= 200) begin
         n_checks++; n_err++;
         $display("FAIL frame_sync: an=%h, required 7f within 200 cycles", an);
         return;
      end
      @(negedge clock); #1;
      for (int f = 0; f < nframes; f++) begin
         for (int i = 0; i < 8; i++) begin
            x.an  = ~(one << i);
            x.seg = segs[i*7 +: 7];
            exp_q.push_back(x);
         end
      end
      t = 0;
      while (exp_q.size() > 0 && t < 400) begin @(posedge clock); t++; end
      if (exp_q.size() > 0) begin
         n_checks++; n_err++;
         $display("FAIL frame_drain: %0d slots not seen, required 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   logic [6:0]  z;
   logic [55:0] f_blank, f_clr, f_42, f_err;

   initial begin
`ifdef DISPLAY_LZB_EN
      z = 7'h7F;
`else
      z = 7'h40;
`endif
      f_blank = {8{7'h7F}};
      f_clr   = {7'h12, {7{7'h7F}}};
      f_42    = {z, z, z, z, z, z, 7'h19, 7'h24};
      f_err   = {{4{7'h7F}}, 7'h06, 7'h2F, 7'h2F, 7'h23};

      // 1: reset state, first slot, scan sequence with wrap
      #1 reset = 1'b1;
      #2;
      check("rst_an", an, 8'hFF);
      check("rst_seg", {1'b0, seg}, 8'h7F);
      check("rst_dp", {7'b0, dp}, 8'h01);
      @(negedge clock); @(negedge clock);
      reset = 1'b0;
      @(posedge clock); #1;
      check("first_an", an, 8'hFE);
      check("first_seg", {1'b0, seg}, 8'h7F);
      chk_len = 1'b1;
      push_frame(f_blank, 2);
      chk_len = 1'b0;

      // 2: old content is cleared on PRONTA -> OCUPADA
      @(negedge clock); status = S_OCUPADA; pos = 4'd3; dig = 4'd8;
      @(negedge clock); pos = 4'hF;
      @(negedge clock); status = S_PRONTA;
      @(negedge clock); @(negedge clock);
      status = S_OCUPADA; pos = 4'd0; dig = 4'd5;
      push_frame(f_clr, 1);

      // 3: result 00000042 written pos 7..0
      for (int k = 0; k < 8; k++) begin
         @(negedge clock);
         pos = 4'(7 - k);
         dig = (k == 0) ? 4'd2 : (k == 1) ? 4'd4 : 4'd0;
      end
      @(negedge clock); pos = 4'hF;
      push_frame(f_42, 1);

      // 4: ERRO overlay, then buffer returns
      @(negedge clock); status = S_ERRO;
      push_frame(f_err, 1);
      @(negedge clock); status = S_OCUPADA;
      push_frame(f_42, 1);

      // 5: illegal pos, illegal dig, write attempt while IMPRIME
      @(negedge clock); pos = 4'd9; dig = 4'd3;
      repeat (3) @(negedge clock);
      pos = 4'd2; dig = 4'd12;
      repeat (3) @(negedge clock);
      status = S_IMPRIME; pos = 4'd6; dig = 4'd1;
      repeat (3) @(negedge clock);
      pos = 4'hF;
      push_frame(f_42, 1);

      // 6: asynchronous reset between edges, mid-frame
      repeat (13) @(posedge clock);
      #2 reset = 1'b1;
      #1;
      check("async_an", an, 8'hFF);
      check("async_seg", {1'b0, seg}, 8'h7F);
      status = S_PRONTA;
      @(negedge clock); @(negedge clock);
      reset = 1'b0;
      @(posedge clock); #1;
      check("restart_an", an, 8'hFE);
      push_frame(f_blank, 1);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, required finish earlier");
      $fatal(1, "watchdog");
   end

endmodule
